// File: rtl/eth_pkg.sv
// Shared Ethernet/IPv4/UDP constants, the UDP TX state encoding and the
// one's-complement checksum fold used by the framers.
package eth_pkg;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] IP_VER_IHL     = 16'h4500;  // version 4, IHL 5, TOS 0
  localparam logic [15:0] IP_FLAGS_DF    = 16'h4000;  // don't-fragment, offset 0
  localparam logic [7:0]  IP_TTL         = 8'd64;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'd17;
  // Eth + IPv4 + UDP = 42 bytes = 10.5 words; word 10 also carries payload.
  localparam int          ETH_HDR_WORDS  = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CSUM,
    ST_REQ,
    ST_SEND
  } udp_tx_state_e;

  // Fold a 32-bit sum of halfwords twice into 16 bits and invert.
  function automatic logic [15:0] fold_csum(input logic [31:0] acc);
    logic [31:0] s;
    s = {16'h0000, acc[31:16]} + {16'h0000, acc[15:0]};
    s = {16'h0000, s[31:16]} + {16'h0000, s[15:0]};
    return ~s[15:0];
  endfunction

endpackage

// File: rtl/eth_udp_buf.sv
// Simple dual-port payload buffer with a registered read port.
module eth_udp_buf #(
  parameter int DEPTH = 360,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [31:0]   i_wr_data,
  input  logic [AW-1:0] i_rd_addr,
  output logic [31:0]   o_rd_data
);

  logic [31:0] r_mem [DEPTH];

  // Write port plus one-cycle registered read (read-before-write on a collision).
  // NOTE: the array and read register have no reset so the tools can map them to
  // block RAM; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/eth_udp_tx.sv
// UDP transmit framer: buffers one channel block, computes the IPv4 header
// checksum, requests the TX port and streams Eth+IPv4+UDP+payload as 32-bit words.
module eth_udp_tx
  import eth_pkg::*;
#(
  parameter int          MAX_WORDS = 360,
  parameter logic [15:0] SRC_PORT  = 16'h4000,
  parameter logic [15:0] DST_PORT  = 16'h4000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [47:0] i_self_mac,
  input  logic [31:0] i_self_ip,
  input  logic [47:0] i_dst_mac,
  input  logic [31:0] i_dst_ip,
  input  logic [31:0] i_ch_data,
  input  logic        i_ch_vld,
  input  logic [9:0]  i_ch_cntr,
  input  logic        i_ch_complete,
  output logic        o_req,
  input  logic        i_gnt,
  output logic [31:0] o_data,
  output logic        o_vld,
  input  logic        i_rdy,
  output logic        o_sop,
  output logic        o_eop,
  output logic [1:0]  o_mod,
  output logic [15:0] o_drop_cnt
);

  localparam int AW = $clog2(MAX_WORDS);                  // buffer address
  localparam int NW = $clog2(MAX_WORDS + 1);              // payload word count
  localparam int WW = $clog2(MAX_WORDS + ETH_HDR_WORDS);  // frame word index

  udp_tx_state_e r_state, w_next_state;

  logic [NW-1:0] r_wr_max, w_wr_n, w_n_eff;
  logic [47:0]   r_smac, r_dmac;
  logic [31:0]   r_sip, r_dip;
  logic [15:0]   r_ip_id, r_csum, r_drop_cnt, r_lo_hold;
  logic [WW-1:0] r_widx, w_nidx, w_last_idx;
  logic [AW-1:0] r_rd_addr, w_rd_addr;
  logic [31:0]   r_data, w_word, w_rd_data, w_csum_acc;
  logic          r_vld, r_sop, r_eop;
  logic [1:0]    r_mod;
  logic          w_wr_en, w_start, w_load_first, w_accept, w_frame_done;
  logic          w_is_last, w_rd_adv;
  logic [15:0]   w_tot_len, w_udp_len;

  // Buffer writes are only taken while idle and in range; N tracks highest index + 1.
  assign w_wr_en   = (r_state == ST_IDLE) && i_ch_vld && (i_ch_cntr < 10'(MAX_WORDS));
  assign w_wr_n    = NW'(i_ch_cntr) + NW'(1);
  assign w_n_eff   = (w_wr_en && (w_wr_n > r_wr_max)) ? w_wr_n : r_wr_max;
  assign w_start   = (r_state == ST_IDLE) && i_ch_complete && (w_n_eff != '0);

  assign w_tot_len = 16'd28 + 16'({r_wr_max, 2'b00});
  assign w_udp_len = 16'd8 + 16'({r_wr_max, 2'b00});
  // Header checksum field itself is zero and so omitted from the sum.
  assign w_csum_acc = 32'(IP_VER_IHL) + 32'(w_tot_len) + 32'(r_ip_id) + 32'(IP_FLAGS_DF)
                    + 32'({IP_TTL, IP_PROTO_UDP}) + 32'(r_sip[31:16]) + 32'(r_sip[15:0])
                    + 32'(r_dip[31:16]) + 32'(r_dip[15:0]);

  eth_udp_buf #(.DEPTH(MAX_WORDS), .AW(AW)) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (i_ch_cntr[AW-1:0]),
    .i_wr_data (i_ch_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state decode and per-cycle control strobes.
  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    o_req        = 1'b0;
    w_load_first = 1'b0;
    w_accept     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE: if (w_start) w_next_state = ST_CSUM;
      ST_CSUM: w_next_state = ST_REQ;
      ST_REQ: begin
        o_req = 1'b1;
        if (i_gnt) begin
          w_load_first = 1'b1;
          w_next_state = ST_SEND;
        end
      end
      ST_SEND: begin
        if (r_vld && i_rdy) begin
          w_accept = 1'b1;
          if (r_eop) begin
            w_frame_done = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Index of the word about to be loaded into the output register.
  assign w_nidx     = w_load_first ? '0 : r_widx + WW'(1);
  assign w_last_idx = WW'(ETH_HDR_WORDS - 1) + WW'(r_wr_max);
  assign w_is_last  = (w_nidx == w_last_idx);

  // Read address always points at the payload word the next load needs, so the
  // registered RAM output is ready in time and stays put while the sink stalls.
  assign w_rd_adv  = w_accept && !r_eop && (r_widx >= WW'(ETH_HDR_WORDS - 2))
                   && ((NW'(r_rd_addr) + NW'(1)) < r_wr_max);
  assign w_rd_addr = w_frame_done ? '0 : r_rd_addr + AW'(w_rd_adv);

  // Frame word multiplexer: fixed header words, then payload shifted by a halfword.
  always_comb begin
    w_word = '0;
    if (w_nidx < WW'(ETH_HDR_WORDS - 1)) begin
      case (w_nidx[3:0])
        4'd0:    w_word = r_dmac[47:16];
        4'd1:    w_word = {r_dmac[15:0], r_smac[47:32]};
        4'd2:    w_word = r_smac[31:0];
        4'd3:    w_word = {ETHERTYPE_IPV4, IP_VER_IHL};
        4'd4:    w_word = {w_tot_len, r_ip_id};
        4'd5:    w_word = {IP_FLAGS_DF, IP_TTL, IP_PROTO_UDP};
        4'd6:    w_word = {r_csum, r_sip[31:16]};
        4'd7:    w_word = {r_sip[15:0], r_dip[31:16]};
        4'd8:    w_word = {r_dip[15:0], SRC_PORT};
        4'd9:    w_word = {DST_PORT, w_udp_len};
        default: w_word = '0;
      endcase
    end else begin
      w_word = {r_lo_hold, w_is_last ? 16'h0000 : w_rd_data[31:16]};
    end
  end

  // Block bookkeeping: payload length, address snapshot, checksum, frame id, drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_max   <= '0;
      r_smac     <= '0;
      r_dmac     <= '0;
      r_sip      <= '0;
      r_dip      <= '0;
      r_csum     <= '0;
      r_ip_id    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_frame_done)  r_wr_max <= '0;
      else if (w_wr_en)  r_wr_max <= w_n_eff;
      if (w_start) begin
        r_smac <= i_self_mac;
        r_dmac <= i_dst_mac;
        r_sip  <= i_self_ip;
        r_dip  <= i_dst_ip;
      end
      if (r_state == ST_CSUM) r_csum <= fold_csum(w_csum_acc);
      if (w_frame_done)       r_ip_id <= r_ip_id + 16'd1;
      if ((r_state != ST_IDLE) && i_ch_complete && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  // Output word register: loads on grant and on each accepted word, clears after eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_widx    <= '0;
      r_data    <= '0;
      r_vld     <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
      r_mod     <= '0;
      r_lo_hold <= '0;
      r_rd_addr <= '0;
    end else begin
      r_rd_addr <= w_rd_addr;
      if (w_load_first || (w_accept && !r_eop)) begin
        r_widx <= w_nidx;
        r_data <= w_word;
        r_vld  <= 1'b1;
        r_sop  <= w_load_first;
        r_eop  <= w_is_last;
        r_mod  <= w_is_last ? 2'd2 : 2'd0;
        if (w_load_first)
          r_lo_hold <= '0;
        else if (w_nidx >= WW'(ETH_HDR_WORDS - 1))
          r_lo_hold <= w_rd_data[15:0];
      end else if (w_frame_done) begin
        r_widx <= '0;
        r_data <= '0;
        r_vld  <= 1'b0;
        r_sop  <= 1'b0;
        r_eop  <= 1'b0;
        r_mod  <= '0;
      end
    end
  end

  assign o_data     = r_data;
  assign o_vld      = r_vld;
  assign o_sop      = r_sop;
  assign o_eop      = r_eop;
  assign o_mod      = r_mod;
  assign o_drop_cnt = r_drop_cnt;

endmodule
